// File: rtl/panic_deframer_pkg.sv
// Descriptor field map (the panic_define.v field layout) and shared helpers for
// the PANIC deframer. The `PANIC_DESC_* macros describe where the descriptor
// fields sit in the first beat of a packet.

`ifndef PANIC_DEFINE_V
`define PANIC_DEFINE_V
`define PANIC_DESC_WIDTH    64
`define PANIC_DESC_LEN_OF   0
`define PANIC_DESC_LEN_SIZE 16
`define PANIC_DESC_DROP_OF  16
`endif

package panic_deframer_pkg;

    localparam int unsigned DescWidth   = `PANIC_DESC_WIDTH;
    localparam int unsigned DescLenOf   = `PANIC_DESC_LEN_OF;
    localparam int unsigned DescLenSize = `PANIC_DESC_LEN_SIZE;
    localparam int unsigned DescDropOf  = `PANIC_DESC_DROP_OF;

    // Drop flag carried in the descriptor.
    function automatic logic desc_drop(input logic [DescWidth-1:0] desc);
        return desc[DescDropOf];
    endfunction

    // Expected payload length in bytes carried in the descriptor.
    function automatic logic [DescLenSize-1:0] desc_len(input logic [DescWidth-1:0] desc);
        return desc[DescLenOf +: DescLenSize];
    endfunction

endpackage

// File: rtl/panic_desc_reg.sv
// One-entry valid/ready register holding the most recently extracted
// descriptor. Accepts a new entry in the same cycle the held one drains.

module panic_desc_reg #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [USER_WIDTH-1:0] out_user,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [USER_WIDTH-1:0] user_q, user_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_user  = user_q;
    assign out_valid = valid_q;

    // Load on an input handshake, otherwise empty once the consumer takes the entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        user_d  = user_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
            user_d  = in_user;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            user_q  <= user_d;
        end
    end

endmodule

// File: rtl/panic_deframer.sv
// PANIC deframer: splits each crossbar packet into a descriptor (first beat)
// and a payload stream (remaining beats), or discards the payload when the
// descriptor's drop flag is set. Defining PANIC_DEFRAMER_LEN_CHECK_EN adds a
// payload byte counter that flags length mismatches on stat_len_err.

module panic_deframer
    import panic_deframer_pkg::*;
#(
    parameter int unsigned SWITCH_DATA_WIDTH = 512,
    parameter int unsigned SWITCH_KEEP_WIDTH = SWITCH_DATA_WIDTH / 8,
    parameter int unsigned SWITCH_DEST_WIDTH = 3,
    parameter int unsigned SWITCH_USER_WIDTH = 1,
    parameter int unsigned LEN_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [SWITCH_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [SWITCH_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic [SWITCH_DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [SWITCH_USER_WIDTH-1:0] s_axis_tuser,

    output logic [`PANIC_DESC_WIDTH-1:0] m_desc_tdata,
    output logic                         m_desc_tvalid,
    input  logic                         m_desc_tready,
    output logic [SWITCH_USER_WIDTH-1:0] m_desc_tuser,

    output logic [SWITCH_DATA_WIDTH-1:0] m_data_axis_tdata,
    output logic [SWITCH_KEEP_WIDTH-1:0] m_data_axis_tkeep,
    output logic                         m_data_axis_tvalid,
    input  logic                         m_data_axis_tready,
    output logic                         m_data_axis_tlast,

    output logic                         stat_drop,
    output logic                         stat_len_err,
    output logic [31:0]                  stat_pkt_cnt
);

    typedef enum logic [1:0] {
        StHead    = 2'd0,
        StData    = 2'd1,
        StDiscard = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           stat_drop_q, stat_drop_d;
    logic [31:0]    pkt_cnt_q, pkt_cnt_d;

    logic [DescWidth-1:0] head_desc;
    logic                 desc_in_valid;
    logic                 desc_in_ready;
    logic                 s_hs;

    assign head_desc     = s_axis_tdata[DescWidth-1:0];
    assign desc_in_valid = (state_q == StHead) && s_axis_tvalid;
    assign s_hs          = s_axis_tvalid && s_axis_tready;

    panic_desc_reg #(
        .DATA_WIDTH (DescWidth),
        .USER_WIDTH (SWITCH_USER_WIDTH)
    ) u_desc_reg (
        .clk       (clk),
        .rst       (rst),
        .in_data   (head_desc),
        .in_user   (s_axis_tuser),
        .in_valid  (desc_in_valid),
        .in_ready  (desc_in_ready),
        .out_data  (m_desc_tdata),
        .out_user  (m_desc_tuser),
        .out_valid (m_desc_tvalid),
        .out_ready (m_desc_tready)
    );

    // Payload is a straight wire-through; only tvalid is gated by the state.
    assign m_data_axis_tdata  = s_axis_tdata;
    assign m_data_axis_tkeep  = s_axis_tkeep;
    assign m_data_axis_tlast  = s_axis_tlast;
    assign m_data_axis_tvalid = (state_q == StData) && s_axis_tvalid;

    // Input backpressure follows whichever sink owns the current beat.
    always_comb begin
        s_axis_tready = 1'b0;
        unique case (state_q)
            StHead:    s_axis_tready = desc_in_ready;
            StData:    s_axis_tready = m_data_axis_tready;
            StDiscard: s_axis_tready = 1'b1;
            default:   s_axis_tready = 1'b0;
        endcase
    end

    // Next-state, drop pulse and delivered-descriptor count.
    always_comb begin
        state_d     = state_q;
        stat_drop_d = 1'b0;
        pkt_cnt_d   = pkt_cnt_q + {31'd0, (m_desc_tvalid && m_desc_tready)};
        unique case (state_q)
            StHead: begin
                if (s_hs && !s_axis_tlast) begin
                    if (desc_drop(head_desc)) begin
                        state_d     = StDiscard;
                        stat_drop_d = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData, StDiscard: begin
                if (s_hs && s_axis_tlast) begin
                    state_d = StHead;
                end
            end
            default: state_d = StHead;
        endcase
    end

    // Parser state and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHead;
            stat_drop_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            stat_drop_q <= stat_drop_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign stat_drop    = stat_drop_q;
    assign stat_pkt_cnt = pkt_cnt_q;

`ifdef PANIC_DEFRAMER_LEN_CHECK_EN
    logic [LEN_WIDTH-1:0] len_cnt_q, len_cnt_d;
    logic [LEN_WIDTH-1:0] exp_len_q, exp_len_d;
    logic [LEN_WIDTH-1:0] beat_bytes;
    logic [LEN_WIDTH-1:0] final_cnt;
    logic                 len_err_q, len_err_d;

    // Bytes enabled on the current beat.
    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < SWITCH_KEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + LEN_WIDTH'(s_axis_tkeep[i]);
        end
    end

    // Count payload bytes (wrapping) and compare against the descriptor on tlast.
    always_comb begin
        len_cnt_d = len_cnt_q;
        exp_len_d = exp_len_q;
        len_err_d = 1'b0;
        final_cnt = len_cnt_q + beat_bytes;
        if (state_q == StHead && s_hs && !s_axis_tlast && !desc_drop(head_desc)) begin
            exp_len_d = LEN_WIDTH'(desc_len(head_desc));
            len_cnt_d = '0;
        end
        if (state_q == StData && s_hs) begin
            if (s_axis_tlast) begin
                len_err_d = (final_cnt != exp_len_q);
                len_cnt_d = '0;
            end else begin
                len_cnt_d = final_cnt;
            end
        end
    end

    // Length checker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_cnt_q <= '0;
            exp_len_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_cnt_q <= len_cnt_d;
            exp_len_q <= exp_len_d;
            len_err_q <= len_err_d;
        end
    end

    assign stat_len_err = len_err_q;

    logic unused_sink;
    assign unused_sink = ^s_axis_tdest;
`else
    assign stat_len_err = 1'b0;

    // Routing tag and counter width have no consumer in this build.
    logic unused_sink;
    assign unused_sink = ^{s_axis_tdest, LEN_WIDTH};
`endif

endmodule

// File: tb/tb_panic_deframer.sv
// Self-checking bench for panic_deframer: directed scenarios plus randomized
// packets, all checked against a stream-level reference model.
`timescale 1ns/1ps

module tb_panic_deframer;
    import panic_deframer_pkg::*;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned DESTW = 3;
    localparam int unsigned UW = 1;
    localparam int unsigned LW = 16;
`ifdef PANIC_DEFRAMER_LEN_CHECK_EN
    localparam bit LenChk = 1'b1;
`else
    localparam bit LenChk = 1'b0;
`endif

    typedef enum int {KHead, KPass, KDrop} kind_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic s_axis_tvalid = 1'b0;
    logic s_axis_tready;
    logic s_axis_tlast = 1'b0;
    logic [DESTW-1:0] s_axis_tdest = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic [DescWidth-1:0] m_desc_tdata;
    logic m_desc_tvalid;
    logic m_desc_tready = 1'b0;
    logic [UW-1:0] m_desc_tuser;
    logic [DW-1:0] m_data_axis_tdata;
    logic [KW-1:0] m_data_axis_tkeep;
    logic m_data_axis_tvalid;
    logic m_data_axis_tready = 1'b0;
    logic m_data_axis_tlast;
    logic stat_drop, stat_len_err;
    logic [31:0] stat_pkt_cnt;

    panic_deframer dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdest(s_axis_tdest),
        .s_axis_tuser(s_axis_tuser),
        .m_desc_tdata(m_desc_tdata), .m_desc_tvalid(m_desc_tvalid),
        .m_desc_tready(m_desc_tready), .m_desc_tuser(m_desc_tuser),
        .m_data_axis_tdata(m_data_axis_tdata), .m_data_axis_tkeep(m_data_axis_tkeep),
        .m_data_axis_tvalid(m_data_axis_tvalid), .m_data_axis_tready(m_data_axis_tready),
        .m_data_axis_tlast(m_data_axis_tlast),
        .stat_drop(stat_drop), .stat_len_err(stat_len_err), .stat_pkt_cnt(stat_pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [DW+KW:0] act,
                              input logic [DW+KW:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    kind_e cur_kind = KHead;          // what the beat on the input represents
    bit mon_en = 1'b0;
    logic [DescWidth+UW-1:0] desc_exp[$];
    logic [DW+KW:0] data_exp[$];
    int unsigned pkt_bytes = 0;
    logic [LW-1:0] pkt_len = '0;
    bit exp_drop = 0, exp_lenerr = 0, exp_desc_valid = 0;
    logic [31:0] pkt_cnt_exp = '0;
    bit prev_stall = 0;
    logic [DescWidth+UW-1:0] prev_desc = '0;
    int n_drop = 0, n_lenerr = 0, n_data = 0, n_desc = 0;
    int desc_mode = 0, data_mode = 0;  // 0 always ready, 1 random, 2 never

    task automatic model_clear();
        desc_exp.delete();
        data_exp.delete();
        pkt_bytes = 0;
        exp_drop = 0;
        exp_lenerr = 0;
        exp_desc_valid = 0;
        pkt_cnt_exp = '0;
        prev_stall = 0;
        cur_kind = KHead;
    endtask

    task automatic monitor_cycle();
        bit s_hs, d_hs, m_hs;
        logic [DW+KW:0] e;
        logic [DescWidth+UW-1:0] de;
        s_hs = s_axis_tvalid && s_axis_tready;
        d_hs = m_desc_tvalid && m_desc_tready;
        m_hs = m_data_axis_tvalid && m_data_axis_tready;
        check("stat_drop", stat_drop, exp_drop);
        check("stat_len_err", stat_len_err, exp_lenerr);
        check("stat_pkt_cnt", stat_pkt_cnt, pkt_cnt_exp);
        if (stat_drop) n_drop++;
        if (stat_len_err) n_lenerr++;
        if (exp_desc_valid) check("desc_valid_after_head", m_desc_tvalid, 1);
        if (prev_stall) check("desc_stable", {m_desc_tuser, m_desc_tdata}, prev_desc);
        exp_drop = 0;
        exp_lenerr = 0;
        exp_desc_valid = 0;
        case (cur_kind)
            KHead: begin
                check("head_tready", s_axis_tready, !m_desc_tvalid || m_desc_tready);
                check("head_data_tvalid", m_data_axis_tvalid, 0);
            end
            KDrop: begin
                check("discard_tready", s_axis_tready, 1);
                check("discard_data_tvalid", m_data_axis_tvalid, 0);
            end
            default: begin
                check("data_tready", s_axis_tready, m_data_axis_tready);
                check("data_tvalid", m_data_axis_tvalid, s_axis_tvalid);
            end
        endcase
        if (s_hs) begin
            case (cur_kind)
                KHead: begin
                    desc_exp.push_back({s_axis_tuser, s_axis_tdata[DescWidth-1:0]});
                    exp_desc_valid = 1;
                    if (!s_axis_tlast) begin
                        if (s_axis_tdata[DescDropOf]) exp_drop = 1;
                        else begin
                            pkt_len = s_axis_tdata[DescLenOf +: LW];
                            pkt_bytes = 0;
                        end
                    end
                end
                KPass: begin
                    data_exp.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
                    pkt_bytes += $countones(s_axis_tkeep);
                    if (s_axis_tlast) exp_lenerr = LenChk && ((pkt_bytes % 65536) != pkt_len);
                end
                default: ;
            endcase
        end
        if (m_hs) begin
            if (data_exp.size() == 0) check("data_unexpected", 1, 0);
            else begin
                e = data_exp.pop_front();
                check_wide("data_beat", {m_data_axis_tlast, m_data_axis_tkeep, m_data_axis_tdata}, e);
                n_data++;
            end
        end
        if (d_hs) begin
            if (desc_exp.size() == 0) check("desc_unexpected", 1, 0);
            else begin
                de = desc_exp.pop_front();
                check("desc", {m_desc_tuser, m_desc_tdata}, de);
                n_desc++;
            end
            pkt_cnt_exp++;
        end
        prev_stall = m_desc_tvalid && !m_desc_tready;
        prev_desc = {m_desc_tuser, m_desc_tdata};
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en && !rst) monitor_cycle();
    end

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Output sinks.
    initial forever begin
        @(posedge clk);
        #1;
        m_desc_tready = pick(desc_mode);
        m_data_axis_tready = pick(data_mode);
    end

    // ---------------- drivers (entered and left at posedge+1) ----------------
    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] make_desc(input logic [LW-1:0] len, input bit drop);
        logic [DW-1:0] r;
        r = rand_wide();
        r[DescLenOf +: LW] = len;
        r[DescDropOf] = drop;
        return r;
    endfunction

    task automatic present(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last);
        s_axis_tdata = d;
        s_axis_tkeep = k;
        s_axis_tlast = last;
        s_axis_tuser = UW'($urandom_range(0, 1));
        s_axis_tdest = DESTW'($urandom);
        s_axis_tvalid = 1'b1;
    endtask

    task automatic wait_hs();
        int n;
        bit hs;
        n = 0;
        hs = 0;
        while (!hs) begin
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            n++;
            if (!hs && n > 300) begin
                checks++;
                failures++;
                $display("FAIL input_handshake_timeout: no tready after %0d cycles", n);
                break;
            end
        end
        // Advance the stream position for the beat just accepted.
        if (cur_kind == KHead) begin
            if (!s_axis_tlast) cur_kind = s_axis_tdata[DescDropOf] ? KDrop : KPass;
        end else if (s_axis_tlast) begin
            cur_kind = KHead;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last,
                             input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        present(d, k, last);
        wait_hs();
    endtask

    task automatic send_packet(input logic [LW-1:0] len, input bit drop, input int nbeats,
                               input logic [KW-1:0] keep_last, input int gapmax);
        send_beat(make_desc(len, drop), '1, nbeats == 0, $urandom_range(0, gapmax));
        for (int b = 0; b < nbeats; b++) begin
            send_beat(rand_wide(), (b == nbeats - 1) ? keep_last : '1, b == nbeats - 1,
                      $urandom_range(0, gapmax));
        end
    endtask

    task automatic drain();
        int n;
        desc_mode = 0;
        data_mode = 0;
        n = 0;
        while ((desc_exp.size() != 0 || data_exp.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", desc_exp.size() + data_exp.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_desc_tvalid"}, m_desc_tvalid, 0);
        check({tag, "_desc_tdata"}, m_desc_tdata, 0);
        check({tag, "_desc_tuser"}, m_desc_tuser, 0);
        check({tag, "_pkt_cnt"}, stat_pkt_cnt, 0);
        check({tag, "_stat_drop"}, stat_drop, 0);
        check({tag, "_stat_len_err"}, stat_len_err, 0);
        check({tag, "_data_tvalid"}, m_data_axis_tvalid, 0);
    endtask

    initial begin
        int d0, m0, l0, p0;
        logic [DW-1:0] desc_a;
        int nb;
        logic [KW-1:0] kl;
        int exact_bytes;

        // Reset state.
        #2;
        check_reset_outputs("reset");
        check("reset_s_tready", s_axis_tready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        mon_en = 1'b1;

        // LEN=128 + two full beats: no length error, one descriptor.
        d0 = n_desc; m0 = n_data; l0 = n_lenerr;
        send_packet(16'd128, 0, 2, '1, 0);
        drain();
        check("req030_desc_count", n_desc - d0, 1);
        check("req030_data_count", n_data - m0, 2);
        check("req030_len_err", n_lenerr - l0, 0);
        check("req030_pkt_cnt", stat_pkt_cnt, 1);

        // LEN=100 + one 64-byte beat: mismatch flagged only with the checker built in.
        l0 = n_lenerr;
        send_packet(16'd100, 0, 1, '1, 0);
        drain();
        check("req031_len_err", n_lenerr - l0, LenChk ? 1 : 0);

        // Drop + three beats: drop pulse, descriptor out, no payload.
        d0 = n_desc; m0 = n_data; p0 = n_drop;
        send_packet(16'd192, 1, 3, '1, 1);
        drain();
        check("req032_drop", n_drop - p0, 1);
        check("req032_desc", n_desc - d0, 1);
        check("req032_data", n_data - m0, 0);

        // Descriptor sink stalled: second descriptor-only beat must wait.
        desc_mode = 2;
        d0 = n_desc;
        desc_a = make_desc(16'd7, 0);
        send_beat(desc_a, '1, 1, 0);
        present(make_desc(16'd9, 1), '1, 1);
        repeat (3) begin
            @(negedge clk);
            check("req033_stall_tready", s_axis_tready, 0);
            check("req033_held_desc", m_desc_tdata, desc_a[DescWidth-1:0]);
            @(posedge clk);
            #1;
        end
        desc_mode = 0;
        wait_hs();
        drain();
        check("req033_desc", n_desc - d0, 2);

        // Ten-beat packet with 50% payload backpressure.
        m0 = n_data;
        data_mode = 1;
        send_packet(16'd640, 0, 10, '1, 0);
        drain();
        check("req034_data", n_data - m0, 10);

        // Reset during beat 3 of 5; the following beat is a fresh descriptor.
        desc_mode = 1;
        send_beat(make_desc(16'd320, 0), '1, 0, 0);
        send_beat(rand_wide(), '1, 0, 0);
        send_beat(rand_wide(), '1, 0, 0);
        present(rand_wide(), '1, 0);
        #2;
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        d0 = n_desc;
        s_axis_tlast = 1'b1;
        wait_hs();
        drain();
        check("req035_desc", n_desc - d0, 1);
        check("req035_pkt_cnt", stat_pkt_cnt, 1);

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            desc_mode = $urandom_range(0, 1);
            data_mode = $urandom_range(0, 1);
            nb = $urandom_range(0, 5);
            kl = KW'({$urandom, $urandom});
            exact_bytes = (nb > 0) ? (nb - 1) * KW + $countones(kl) : 0;
            send_packet(($urandom_range(0, 1) != 0) ? LW'(exact_bytes) : LW'($urandom),
                        $urandom_range(0, 3) == 0, nb, kl, 2);
        end
        drain();
        check("final_pkt_cnt", stat_pkt_cnt, pkt_cnt_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panic_deframer.md
PANIC_DEFRAMER -- requirements
Module: panic_deframer

Interface
REQ-001 SHALL have parameter SWITCH_DATA_WIDTH, default 512, crossbar beat width.
REQ-002 SHALL have parameter SWITCH_KEEP_WIDTH, default SWITCH_DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have parameter SWITCH_DEST_WIDTH, default 3, crossbar port address width.
REQ-004 SHALL have parameter SWITCH_USER_WIDTH, default 1, tuser width (1 = bypass, no cell memory).
REQ-005 SHALL have parameter LEN_WIDTH, default 16, byte-counter width.
REQ-006 SHALL use one clock; reset is asynchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, async active-high reset.
REQ-007 SHALL have s_axis_tdata/tkeep/tvalid/tready/tlast/tdest/tuser, crossbar input (tready is an output), widths per parameters.
REQ-008 SHALL have m_desc_tdata out `PANIC_DESC_WIDTH, m_desc_tvalid out 1, m_desc_tready in 1, m_desc_tuser out SWITCH_USER_WIDTH: extracted descriptor.
REQ-009 SHALL have m_data_axis_tdata/tkeep/tvalid/tlast out and m_data_axis_tready in: payload stream.
REQ-010 SHALL have stat_drop out 1, stat_len_err out 1 (one-cycle pulses), and stat_pkt_cnt out 32 (descriptors delivered).

Function
REQ-011 SHALL run an FSM with states HEAD, DATA and DISCARD; the reset state is HEAD.
REQ-012 In HEAD, s_axis_tready SHALL equal (!m_desc_tvalid || m_desc_tready).
REQ-013 A HEAD handshake SHALL latch tdata[`PANIC_DESC_WIDTH-1:0] and tuser into a one-entry descriptor register and set m_desc_tvalid the next cycle.
REQ-014 m_desc_tvalid SHALL hold with stable data until m_desc_tready; back-to-back descriptors SHALL be accepted when the register drains in the same cycle.
REQ-015 HEAD beat with tlast=1 (descriptor only) SHALL stay in HEAD.
REQ-016 HEAD beat with tlast=0 and `PANIC_DESC_DROP_OF set SHALL go to DISCARD, pulse stat_drop, and still emit the descriptor.
REQ-017 HEAD beat with tlast=0 and the drop bit clear SHALL go to DATA and load expected length from `PANIC_DESC_LEN_OF.
REQ-018 DATA SHALL pass through combinationally: m_data_axis_* = s_axis_*, and s_axis_tready = m_data_axis_tready.
REQ-019 DATA SHALL accumulate popcount(tkeep) per handshake into a LEN_WIDTH counter that wraps modulo 2^LEN_WIDTH.
REQ-020 A DATA beat with tlast SHALL return the FSM to HEAD and clear the counter.
REQ-021 DISCARD SHALL hold s_axis_tready=1 and m_data_axis_tvalid=0, and return to HEAD on tlast.
REQ-022 stat_pkt_cnt SHALL increment on each m_desc handshake and wrap at 2^32.
REQ-023 m_data_axis_tvalid SHALL be 0 outside DATA.

Reset
REQ-024 rst SHALL asynchronously force: state HEAD, m_desc_tvalid 0, m_desc_tdata 0, m_desc_tuser 0, counter 0, stat_pkt_cnt 0, stat_drop 0, stat_len_err 0.
REQ-025 Reset mid-packet SHALL abandon the packet; the first beat after reset is treated as a descriptor.

Configuration
REQ-026 With PANIC_DEFRAMER_LEN_CHECK_EN defined, the tlast beat in DATA SHALL pulse stat_len_err the next cycle when the final count (including that beat) differs from the expected length.
REQ-027 Without PANIC_DEFRAMER_LEN_CHECK_EN, the byte counter and comparator SHALL be absent and stat_len_err tied 0.

Structure
REQ-028 Descriptor field offsets and sizes (`PANIC_DESC_*) SHALL come from panic_define.v; the FSM state encoding SHALL be local constants.
REQ-029 The descriptor register SHALL be one sub-module, panic_desc_reg (one-entry valid/ready register); all other logic is flat.

Verification
REQ-030 Descriptor (LEN=128, drop=0) + 2 full beats, tlast on 2nd -> 1 descriptor, 2 data beats, stat_len_err=0, stat_pkt_cnt=1.
REQ-031 Descriptor LEN=100 + one beat tkeep=64 ones -> stat_len_err pulses once (check enabled), 0 when disabled.
REQ-032 Descriptor drop=1 + 3 beats -> stat_drop pulse, descriptor emitted, no m_data beats, s_axis_tready=1 throughout.
REQ-033 m_desc_tready=0 with 2 descriptor-only beats -> 2nd beat stalls (tready=0) until 1st is taken; order preserved.
REQ-034 m_data_axis_tready toggling 50% on a 10-beat packet -> all beats delivered in order, none duplicated.
REQ-035 rst asserted during beat 3 of 5 -> outputs clear immediately; next beat is parsed as a descriptor.
